// File: rtl/asteroid_field_controller.sv
// Asteroid stage sequencer: spawns asteroid slots one at a time on a frame
// schedule, retires them as they report deactivation, merges their draw
// requests and pulses stage_done once every slot has spawned and retired.
module asteroid_field_controller #(
   parameter int unsigned NUM_ASTEROIDS     = 4,
   parameter int unsigned SPAWN_INTERVAL    = 32,
   parameter int unsigned FIRST_SPAWN_DELAY = 8,
   localparam int unsigned SelW = (NUM_ASTEROIDS > 1) ? $clog2(NUM_ASTEROIDS) : 1,
   localparam int unsigned RemW = $clog2(NUM_ASTEROIDS + 1)
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     startOfFrame,
   input  logic                     stage_start,
   input  logic [NUM_ASTEROIDS-1:0] asteroid_deactivated,
   input  logic [NUM_ASTEROIDS-1:0] asteroidDR,
   output logic [NUM_ASTEROIDS-1:0] asteroid_enable,
   output logic                     fieldDR,
   output logic [SelW-1:0]          field_select,
   output logic [RemW-1:0]          asteroids_remaining,
   output logic                     stage_busy,
   output logic                     stage_done
);

   // Counter must hold both the initial delay and the reload value.
   localparam int unsigned CntMax = (FIRST_SPAWN_DELAY > SPAWN_INTERVAL - 1) ?
                                    FIRST_SPAWN_DELAY : SPAWN_INTERVAL - 1;
   localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;

   typedef enum logic [1:0] {StIdle, StSpawning, StWaitClear, StDone} state_e;

   state_e state_q, state_d;

   logic [NUM_ASTEROIDS-1:0] enable_q, enable_d;
   logic [NUM_ASTEROIDS-1:0] spawned_q, spawned_d;
   logic [NUM_ASTEROIDS-1:0] retired_q, retired_d;
   logic [CntW-1:0]          frameCnt_q, frameCnt_d;
   logic [RemW-1:0]          remaining_q, remaining_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     fieldDR_q, fieldDR_d;
   logic [SelW-1:0]          fieldSel_q, fieldSel_d;

   logic [NUM_ASTEROIDS-1:0] retireMask;
   logic [NUM_ASTEROIDS-1:0] spawnOneHot;
   logic [RemW-1:0]          retireCnt;
   logic                     spawnEvent;

   // Retire/spawn candidates: which slots retire now and which slot spawns next.
   always_comb begin
      retireMask  = asteroid_deactivated & enable_q;
      retireCnt   = '0;
      spawnOneHot = '0;
      for (int i = 0; i < NUM_ASTEROIDS; i++) begin
         if (retireMask[i]) retireCnt = retireCnt + RemW'(1);
      end
      // Scan downward so the lowest unspawned slot is the one that sticks.
      for (int i = NUM_ASTEROIDS - 1; i >= 0; i--) begin
         if (!spawned_q[i]) begin
            spawnOneHot    = '0;
            spawnOneHot[i] = 1'b1;
         end
      end
      // A restart in the same cycle swallows the frame.
      spawnEvent = (state_q == StSpawning) && startOfFrame && !stage_start &&
                   (frameCnt_q == '0);
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= StIdle;
         enable_q    <= '0;
         spawned_q   <= '0;
         retired_q   <= '0;
         frameCnt_q  <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fieldDR_q   <= 1'b0;
         fieldSel_q  <= '0;
      end else begin
         state_q     <= state_d;
         enable_q    <= enable_d;
         spawned_q   <= spawned_d;
         retired_q   <= retired_d;
         frameCnt_q  <= frameCnt_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fieldDR_q   <= fieldDR_d;
         fieldSel_q  <= fieldSel_d;
      end
   end

   // Next-state logic; stage_start restarts from any state.
   always_comb begin
      state_d = state_q;
      if (stage_start) begin
         state_d = StSpawning;
      end else begin
         unique case (state_q)
            StIdle:      state_d = StIdle;
            StSpawning:  if (spawnEvent && (&(spawned_q | spawnOneHot))) state_d = StWaitClear;
            StWaitClear: if (&retired_q) state_d = StDone;
            StDone:      state_d = StIdle;
            default:     state_d = StIdle;
         endcase
      end
   end

   // Datapath next values: spawn schedule, retirement, completion and draw merge.
   always_comb begin
      enable_d    = enable_q;
      spawned_d   = spawned_q;
      retired_d   = retired_q;
      frameCnt_d  = frameCnt_q;
      remaining_d = remaining_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      // Draw merge only sees slots that were enabled this cycle.
      fieldDR_d  = |(asteroidDR & enable_q);
      fieldSel_d = '0;
      for (int i = NUM_ASTEROIDS - 1; i >= 0; i--) begin
         if (asteroidDR[i] && enable_q[i]) fieldSel_d = SelW'(i);
      end

      if (stage_start) begin
         enable_d    = '0;
         spawned_d   = '0;
         retired_d   = '0;
         frameCnt_d  = CntW'(FIRST_SPAWN_DELAY);
         remaining_d = RemW'(NUM_ASTEROIDS);
         busy_d      = 1'b1;
      end else begin
         unique case (state_q)
            StSpawning, StWaitClear: begin
               enable_d    = (enable_q & ~retireMask) | (spawnEvent ? spawnOneHot : '0);
               retired_d   = retired_q | retireMask;
               remaining_d = remaining_q - retireCnt;
               if (state_q == StSpawning && startOfFrame) begin
                  if (frameCnt_q != '0) begin
                     frameCnt_d = frameCnt_q - CntW'(1);
                  end else begin
                     spawned_d  = spawned_q | spawnOneHot;
                     frameCnt_d = CntW'(SPAWN_INTERVAL - 1);
                  end
               end
            end
            StDone: begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign asteroid_enable     = enable_q;
   assign fieldDR             = fieldDR_q;
   assign field_select        = fieldSel_q;
   assign asteroids_remaining = remaining_q;
   assign stage_busy          = busy_q;
   assign stage_done          = done_q;

endmodule

// File: tb/tb_asteroid_field_controller.sv
// Self-checking bench for asteroid_field_controller: directed test-plan
// sequences with literal expectations, then randomized traffic, all checked
// every cycle against a slot-level behavioural model.
module tb_asteroid_field_controller;

   localparam int N     = 4;
   localparam int INTV  = 3;
   localparam int FIRST = 1;

   logic         clk = 1'b0;
   logic         resetN = 1'b0;
   logic         startOfFrame = 1'b0;
   logic         stage_start = 1'b0;
   logic [N-1:0] asteroid_deactivated = '0;
   logic [N-1:0] asteroidDR = '0;
   logic [N-1:0] asteroid_enable;
   logic         fieldDR;
   logic [1:0]   field_select;
   logic [2:0]   asteroids_remaining;
   logic         stage_busy;
   logic         stage_done;

   int tests = 0;
   int fails = 0;

   asteroid_field_controller #(
      .NUM_ASTEROIDS(N),
      .SPAWN_INTERVAL(INTV),
      .FIRST_SPAWN_DELAY(FIRST)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .startOfFrame(startOfFrame),
      .stage_start(stage_start),
      .asteroid_deactivated(asteroid_deactivated),
      .asteroidDR(asteroidDR),
      .asteroid_enable(asteroid_enable),
      .fieldDR(fieldDR),
      .field_select(field_select),
      .asteroids_remaining(asteroids_remaining),
      .stage_busy(stage_busy),
      .stage_done(stage_done)
   );

   always #5 clk = ~clk;

   // Model: phase 0 idle, 1 spawning, 2 waiting for clear, 3 done.
   int   mPhase, mCnt, mRem, mSel;
   bit   mEn[N], mSp[N], mRt[N];
   bit   mBusy, mDone, mFdr;

   function automatic bit allSet(input bit v[N]);
      for (int i = 0; i < N; i++) if (!v[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic modelReset();
      mPhase = 0; mCnt = 0; mRem = 0; mSel = 0;
      mBusy = 0; mDone = 0; mFdr = 0;
      for (int i = 0; i < N; i++) begin mEn[i] = 0; mSp[i] = 0; mRt[i] = 0; end
   endtask

   // Advance the model across one rising edge using the inputs held before it.
   task automatic modelEdge();
      bit en[N], sp[N], rt[N];
      int phase, cnt, rem, sel;
      bit fdr;
      if (!resetN) begin modelReset(); return; end
      en = mEn; sp = mSp; rt = mRt;
      phase = mPhase; cnt = mCnt; rem = mRem;
      fdr = 0; sel = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (asteroidDR[i] && mEn[i]) begin fdr = 1; sel = i; end
      end
      mDone = 0;
      if (stage_start) begin
         for (int i = 0; i < N; i++) begin en[i] = 0; sp[i] = 0; rt[i] = 0; end
         cnt = FIRST; rem = N; phase = 1; mBusy = 1;
      end else if (mPhase == 1 || mPhase == 2) begin
         for (int i = 0; i < N; i++) begin
            if (asteroid_deactivated[i] && mEn[i]) begin en[i] = 0; rt[i] = 1; rem--; end
         end
         if (mPhase == 2 && allSet(mRt)) phase = 3;
         if (mPhase == 1 && startOfFrame) begin
            if (mCnt > 0) cnt = mCnt - 1;
            else begin
               for (int k = 0; k < N; k++) begin
                  if (!mSp[k]) begin en[k] = 1; sp[k] = 1; break; end
               end
               cnt = INTV - 1;
               if (allSet(sp)) phase = 2;
            end
         end
      end else if (mPhase == 3) begin
         mDone = 1; mBusy = 0; phase = 0;
      end
      mEn = en; mSp = sp; mRt = rt;
      mPhase = phase; mCnt = cnt; mRem = rem; mFdr = fdr; mSel = sel;
   endtask

   function automatic logic [N-1:0] packEn();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = mEn[i];
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Compare every DUT output against the model.
   task automatic compareAll();
      check("enable", int'(asteroid_enable), int'(packEn()));
      check("fieldDR", int'(fieldDR), int'(mFdr));
      check("field_select", int'(field_select), mSel);
      check("remaining", int'(asteroids_remaining), mRem);
      check("stage_busy", int'(stage_busy), int'(mBusy));
      check("stage_done", int'(stage_done), int'(mDone));
   endtask

   task automatic cycle();
      @(posedge clk);
      modelEdge();
      #1;
      compareAll();
   endtask

   task automatic frame();
      startOfFrame = 1; cycle();
      startOfFrame = 0; cycle(); cycle();
   endtask

   task automatic startStage();
      stage_start = 1; cycle(); stage_start = 0;
   endtask

   int spawnFrame[4] = '{2, 5, 8, 11};
   logic [3:0] spawnEn[4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

   initial begin
      modelReset();
      #1;
      compareAll();
      check("lit_reset_enable", int'(asteroid_enable), 0);
      check("lit_reset_busy", int'(stage_busy), 0);
      cycle();
      resetN = 1;
      cycle();

      // Spawn schedule from stage start.
      startStage();
      check("lit_remaining_start", int'(asteroids_remaining), 4);
      for (int f = 1, s = 0; f <= 11; f++) begin
         frame();
         if (s < 4 && f == spawnFrame[s]) begin
            check("lit_spawn_enable", int'(asteroid_enable), int'(spawnEn[s]));
            s++;
         end
      end
      check("lit_remaining_full", int'(asteroids_remaining), 4);

      // Draw merge picks the lowest enabled drawing slot.
      asteroidDR = 4'b1100; cycle();
      check("lit_fieldDR", int'(fieldDR), 1);
      check("lit_field_select", int'(field_select), 2);
      asteroidDR = 4'b0000; cycle();

      // Two slots retire together, then the rest; done two edges later.
      asteroid_deactivated = 4'b0101; cycle();
      check("lit_retire_enable", int'(asteroid_enable), 4'b1010);
      check("lit_retire_remaining", int'(asteroids_remaining), 2);
      asteroid_deactivated = 4'b1010; cycle();
      asteroid_deactivated = 4'b0000; cycle();
      check("lit_done_early", int'(stage_done), 0);
      cycle();
      check("lit_done_pulse", int'(stage_done), 1);
      check("lit_done_busy", int'(stage_busy), 0);
      cycle();
      check("lit_done_single", int'(stage_done), 0);

      // Restart from WAIT_CLEAR.
      startStage();
      for (int f = 0; f < 11; f++) frame();
      asteroid_deactivated = 4'b1010; cycle();
      asteroid_deactivated = 4'b0000;
      check("lit_partial_enable", int'(asteroid_enable), 4'b0101);
      startStage();
      check("lit_restart_enable", int'(asteroid_enable), 0);
      check("lit_restart_remaining", int'(asteroids_remaining), 4);
      frame(); frame();
      check("lit_restart_spawn0", int'(asteroid_enable), 4'b0001);
      for (int f = 0; f < 3; f++) frame();
      check("lit_two_spawned", int'(asteroid_enable), 4'b0011);

      // Asynchronous reset mid-stage.
      #2 resetN = 0;
      #1;
      modelReset();
      compareAll();
      check("lit_async_enable", int'(asteroid_enable), 0);
      check("lit_async_busy", int'(stage_busy), 0);
      cycle(); cycle();
      resetN = 1;
      for (int f = 0; f < 10; f++) frame();
      check("lit_no_done_after_reset", int'(stage_done), 0);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         startOfFrame = ($urandom_range(0, 3) == 0);
         stage_start  = (mPhase == 0) ? ($urandom_range(0, 29) == 0)
                                      : ($urandom_range(0, 399) == 0);
         for (int i = 0; i < N; i++)
            asteroid_deactivated[i] = ($urandom_range(0, 9) == 0);
         asteroidDR = 4'($urandom);
         if ($urandom_range(0, 1999) == 0) resetN = 0;
         cycle();
         resetN = 1;
      end
      startOfFrame = 0; stage_start = 0; asteroid_deactivated = '0; asteroidDR = '0;
      cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/asteroid_field_controller.md
Name: asteroid_field_controller

Overview:
- Sequences a special asteroid stage of NUM_ASTEROIDS asteroid instances. Enables the instances one at a time on a frame-based spawn schedule and retires each one when it reports deactivation.
- Merges the per-asteroid draw requests into one field draw request plus the index of the drawing asteroid.
- Signals stage completion once every asteroid has spawned and been retired.
- Sits between the game/stage FSM and the bank of asteroid instances.

Parameters:
- NUM_ASTEROIDS, 4, number of asteroid slots; range 1..16.
- SPAWN_INTERVAL, 32, frames between consecutive spawns; must be >= 1.
- FIRST_SPAWN_DELAY, 8, frames from stage start to the first spawn; 0 means spawn on the first startOfFrame.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- stage_start  in  1  one-cycle pulse that starts or restarts the stage.
- asteroid_deactivated  in  NUM_ASTEROIDS  per-slot "explosion finished" level from each asteroid.
- asteroidDR  in  NUM_ASTEROIDS  per-slot draw request.
- asteroid_enable  out  NUM_ASTEROIDS  per-slot active flag; gates each asteroid's reset and its collision participation.
- fieldDR  out  1  registered OR of the enabled draw requests.
- field_select  out  $clog2(NUM_ASTEROIDS) (min 1)  registered index of the lowest-indexed enabled drawing slot.
- asteroids_remaining  out  $clog2(NUM_ASTEROIDS+1)  slots not yet retired.
- stage_busy  out  1  high from stage_start until stage_done.
- stage_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values: asteroid_enable=0, fieldDR=0, field_select=0, asteroids_remaining=0, stage_busy=0, stage_done=0, FSM=IDLE, frame counter=0, spawned mask=0, retired mask=0.
- FSM states: IDLE, SPAWNING, WAIT_CLEAR, DONE.
- IDLE: on stage_start:
  - spawned=0, retired=0, asteroids_remaining=NUM_ASTEROIDS.
  - frame counter=FIRST_SPAWN_DELAY.
  - stage_busy=1; go to SPAWNING.
- stage_start in any state other than IDLE restarts the stage in the same way, and clears asteroid_enable on the next edge.
- SPAWNING: frame counter decrements on each startOfFrame while nonzero.
- Spawn event: startOfFrame while counter==0.
  - Sets asteroid_enable and spawned for the lowest index with spawned=0.
  - Reloads counter to SPAWN_INTERVAL-1.
- When the last slot is spawned, go to WAIT_CLEAR in the same edge.
- At most one spawn per frame.
- Retire: asteroid_deactivated[i]=1 while asteroid_enable[i]=1 clears asteroid_enable[i] and sets retired[i] on the next edge. Valid in SPAWNING and WAIT_CLEAR.
- asteroids_remaining decrements by the number of slots retired in that cycle. Several slots retiring in one cycle is legal.
- Deactivation on a non-enabled slot is ignored; a slot is never re-spawned within a stage.
- A spawn of slot j and a retire of slot i in the same cycle are both applied.
- WAIT_CLEAR: when retired is all ones, go to DONE.
- DONE: stage_done=1 for exactly one cycle, stage_busy=0, then IDLE.
- Completion latency: the stage_done edge is 2 cycles after the edge that retired the last slot.
- Draw merge, 1-cycle latency:
  - fieldDR <= |(asteroidDR & asteroid_enable).
  - field_select <= lowest i with asteroidDR[i] & asteroid_enable[i], else holds 0.
  - Draw requests from disabled slots never reach fieldDR.
- startOfFrame is ignored in IDLE, WAIT_CLEAR and DONE.
- stage_start and startOfFrame in the same cycle: the restart wins and the frame is not counted.
- Reset mid-stage returns everything to reset values immediately.

Test Plan (NUM_ASTEROIDS=4, SPAWN_INTERVAL=3, FIRST_SPAWN_DELAY=1):
- Pulse stage_start, then frames -> asteroid_enable steps 0001, 0011, 0111, 1111 at frames 2, 5, 8, 11 after start; asteroids_remaining=4; FSM reaches WAIT_CLEAR at frame 11.
- All enabled; deactivate slots 2 and 0 in the same cycle -> next edge asteroid_enable=1010, asteroids_remaining=2; then deactivate 1 and 3 -> stage_done pulses exactly once 2 cycles later, stage_busy=0.
- Slot 1 deactivated while slot 3 is not yet spawned -> slot 3 still spawns on schedule; slot 1 stays disabled even if asteroid_deactivated[1] drops.
- asteroidDR=1111 with enable=0110 -> one cycle later fieldDR=1, field_select=1; asteroidDR=1001 with the same enable -> fieldDR=0.
- stage_start pulsed while in WAIT_CLEAR with enable=0101 -> enable=0000 next edge, asteroids_remaining=4, spawn sequence restarts from slot 0.
- resetN asserted low during SPAWNING with enable=0011 -> all outputs 0 immediately, without waiting for a clock; no stage_done afterwards without a new stage_start.
